// File: rtl/bg_pkg.sv
// Shared types and default geometry for the scrolling background renderer.
package bg_pkg;
    localparam int BG_ADDR_W  = 18;
    localparam int BG_IDX_W   = 4;
    localparam int DEF_SRC_W  = 500;
    localparam int DEF_SRC_H  = 500;
    localparam int DEF_SCR_W  = 640;
    localparam int DEF_SCR_H  = 480;

    typedef logic [BG_ADDR_W-1:0] addr_t;
    typedef logic [BG_IDX_W-1:0]  idx_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;
endpackage

// File: rtl/bg_delay_line.sv
// Reset-to-zero shift register aligning side-band bits with a fixed-depth pipeline.
// Latency DEPTH cycles; no backpressure, shifts every clock.
module bg_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/scrolling_background.sv
// Scaled, horizontally scrolling background: DDA maps each pixel to a ROM texel address.
// Latency 2+ROM_LAT cycles pixel-to-RGB; no backpressure, one pixel per vga_clk.
module scrolling_background
    import bg_pkg::*;
#(
    parameter int SRC_W   = DEF_SRC_W,
    parameter int SRC_H   = DEF_SRC_H,
    parameter int SCR_W   = DEF_SCR_W,
    parameter int SCR_H   = DEF_SCR_H,
    parameter int ADDR_W  = BG_ADDR_W,
    parameter int IDX_W   = BG_IDX_W,
    parameter int ROM_LAT = 1,
    parameter int STEP_W  = 4
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              scroll_en,
    input  logic [STEP_W-1:0] scroll_step,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic [9:0]        scroll_x
);
    localparam int FX_W  = $clog2(SCR_W) + 1;
    localparam int FY_W  = $clog2(SCR_H) + 1;
    localparam int FXS_W = FX_W + 1;
    localparam int FYS_W = FY_W + 1;

    localparam logic [9:0]        SCR_W_X  = 10'(SCR_W);
    localparam logic [9:0]        SCR_H_Y  = 10'(SCR_H);
    localparam logic [9:0]        LAST_X   = 10'(SCR_W - 1);
    localparam logic [9:0]        LAST_SX  = 10'(SRC_W - 1);
    localparam logic [9:0]        LAST_SY  = 10'(SRC_H - 1);
    localparam logic [10:0]       SRC_W_11 = 11'(SRC_W);
    localparam logic [FX_W:0]     FX_ADD   = FXS_W'(SRC_W);
    localparam logic [FX_W:0]     FX_LIM   = FXS_W'(SCR_W);
    localparam logic [FY_W:0]     FY_ADD   = FYS_W'(SRC_H);
    localparam logic [FY_W:0]     FY_LIM   = FYS_W'(SCR_H);
    localparam logic [ADDR_W-1:0] ROW_ADD  = ADDR_W'(SRC_W);

    logic [9:0]        scroll_x_q, scroll_x_d;
    logic [9:0]        src_x_q, src_x_d, src_y_q, src_y_d;
    logic [FX_W-1:0]   fx_q, fx_d;
    logic [FY_W-1:0]   fy_q, fy_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
    logic              synced_q, synced_d;
    rgb_t              rgb_q, rgb_d;

    logic              frame_start, line_start, in_active, line_end;
    logic [10:0]       scroll_sum;
    logic [9:0]        cur_src_x, cur_src_y;
    logic [FX_W-1:0]   cur_fx;
    logic [FY_W-1:0]   cur_fy;
    logic [ADDR_W-1:0] cur_row_base;
    logic [FX_W:0]     fx_sum;
    logic [FY_W:0]     fy_sum;
    logic [1:0]        align_q;

    assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign line_start  = (DrawX == 10'd0);
    assign in_active   = (DrawX < SCR_W_X) && (DrawY < SCR_H_Y);
    assign line_end    = (DrawX == LAST_X) && (DrawY < SCR_H_Y);
    assign scroll_sum  = {1'b0, scroll_x_q} + 11'(scroll_step);

    always_comb begin
        scroll_x_d = scroll_x_q;
        if (frame_start && scroll_en)
            scroll_x_d = (scroll_sum >= SRC_W_11) ? 10'(scroll_sum - SRC_W_11) : scroll_sum[9:0];

        // Start-of-frame/line resets apply to the current pixel, so it uses the fresh values.
        cur_row_base = frame_start ? '0 : row_base_q;
        cur_src_y    = frame_start ? '0 : src_y_q;
        cur_fy       = frame_start ? '0 : fy_q;
        cur_src_x    = line_start ? scroll_x_d : src_x_q;
        cur_fx       = line_start ? '0 : fx_q;
        fx_sum       = {1'b0, cur_fx} + FX_ADD;
        fy_sum       = {1'b0, cur_fy} + FY_ADD;

        src_x_d = src_x_q;
        fx_d    = fx_q;
        addr_d  = addr_q;
        if (in_active) begin
            addr_d  = cur_row_base + ADDR_W'(cur_src_x);
            src_x_d = cur_src_x;
            fx_d    = fx_sum[FX_W-1:0];
            if (fx_sum >= FX_LIM) begin
                fx_d    = FX_W'(fx_sum - FX_LIM);
                src_x_d = (cur_src_x == LAST_SX) ? 10'd0 : cur_src_x + 10'd1;
            end
        end

        src_y_d    = cur_src_y;
        fy_d       = cur_fy;
        row_base_d = cur_row_base;
        if (line_end) begin
            fy_d = fy_sum[FY_W-1:0];
            if (fy_sum >= FY_LIM) begin
                fy_d = FY_W'(fy_sum - FY_LIM);
                if (cur_src_y != LAST_SY) begin
                    src_y_d    = cur_src_y + 10'd1;
                    row_base_d = cur_row_base + ROW_ADD;
                end
            end
        end

        synced_d = synced_q | frame_start;
        rgb_d    = '0;
        if (align_q[1] && align_q[0])
            rgb_d = {pal_red, pal_green, pal_blue};
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            scroll_x_q <= '0;
            src_x_q    <= '0;
            src_y_q    <= '0;
            fx_q       <= '0;
            fy_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            synced_q   <= 1'b0;
            rgb_q      <= '0;
        end else begin
            scroll_x_q <= scroll_x_d;
            src_x_q    <= src_x_d;
            src_y_q    <= src_y_d;
            fx_q       <= fx_d;
            fy_q       <= fy_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            synced_q   <= synced_d;
            rgb_q      <= rgb_d;
        end
    end

    // blank/synced ride alongside the address register and the ROM stages.
    bg_delay_line #(
        .WIDTH (2),
        .DEPTH (1 + ROM_LAT)
    ) u_align (
        .clk_i  (vga_clk),
        .rst_ni (reset_n),
        .d_i    ({blank, synced_d}),
        .q_o    (align_q)
    );

    assign rom_address = addr_q;
    assign pal_index   = rom_q;
    assign red         = rgb_q.r;
    assign green       = rgb_q.g;
    assign blue        = rgb_q.b;
    assign scroll_x    = scroll_x_q;
endmodule

// File: tb/tb_scrolling_background.sv
// Directed checks of the scrolling background: reset, DDA addressing, scroll wrap, alignment.
module tb_scrolling_background;
    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank, scroll_en;
    logic [3:0]  scroll_step;
    logic [17:0] rom_address, rom_address2;
    logic [3:0]  rom_q, rom_q2, rom2_s1, pal_index, pal_index2;
    logic [3:0]  red, green, blue, red2, green2, blue2;
    logic [9:0]  scroll_x, scroll_x2;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 vga_clk = ~vga_clk;

    scrolling_background dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .scroll_en(scroll_en), .scroll_step(scroll_step), .rom_address(rom_address),
        .rom_q(rom_q), .pal_index(pal_index), .pal_red(pal_index), .pal_green(~pal_index),
        .pal_blue(pal_index ^ 4'h5), .red(red), .green(green), .blue(blue), .scroll_x(scroll_x)
    );

    scrolling_background #(.ROM_LAT(2)) dut2 (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .scroll_en(scroll_en), .scroll_step(scroll_step), .rom_address(rom_address2),
        .rom_q(rom_q2), .pal_index(pal_index2), .pal_red(pal_index2), .pal_green(~pal_index2),
        .pal_blue(pal_index2 ^ 4'h5), .red(red2), .green(green2), .blue(blue2), .scroll_x(scroll_x2)
    );

    // ROM contents: index = low nibble of the address.
    always @(posedge vga_clk) rom_q <= rom_address[3:0];
    always @(posedge vga_clk) begin
        rom2_s1 <= rom_address2[3:0];
        rom_q2  <= rom2_s1;
    end

    function automatic logic [11:0] colour(input int a);
        logic [3:0] i;
        i = 4'(a);
        return {i, ~i, i ^ 4'h5};
    endfunction

    task automatic pix(input int x, input int y, input bit b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; DrawX = 10'd300; DrawY = 10'd10; blank = 1'b1;
        scroll_en = 1'b0; scroll_step = 4'd0;
        repeat (2) @(posedge vga_clk);
        #1;
        n_cmp++; if (rom_address !== 18'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", rom_address); end
        n_cmp++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL reset_rgb: got %h want 000", {red, green, blue}); end
        n_cmp++; if (scroll_x !== 10'd0) begin n_err++; $display("FAIL reset_scroll: got %0d want 0", scroll_x); end
        n_cmp++; if ({red2, green2, blue2} !== 12'h000) begin n_err++; $display("FAIL reset_rgb_lat2: got %h want 000", {red2, green2, blue2}); end
        reset_n = 1'b1;
        for (int x = 300; x < 310; x++) begin
            pix(x, 10, 1'b1);
            n_cmp++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL unsynced_rgb x=%0d: got %h want 000", x, {red, green, blue}); end
        end
    endtask

    task automatic test_row0;
        pix(0, 0, 1'b1);
        n_cmp++; if (rom_address !== 18'd0) begin n_err++; $display("FAIL row0_x0_addr: got %0d want 0", rom_address); end
        pix(1, 0, 1'b1);
        n_cmp++; if (rom_address !== 18'd0) begin n_err++; $display("FAIL row0_x1_addr: got %0d want 0", rom_address); end
        n_cmp++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL row0_early_rgb: got %h want 000", {red, green, blue}); end
        pix(2, 0, 1'b1);
        n_cmp++; if (rom_address !== 18'd1) begin n_err++; $display("FAIL row0_x2_addr: got %0d want 1", rom_address); end
        n_cmp++; if ({red, green, blue} !== 12'h0F5) begin n_err++; $display("FAIL row0_x0_rgb: got %h want 0f5", {red, green, blue}); end
        for (int x = 3; x < 640; x++) pix(x, 0, 1'b1);
        n_cmp++; if (rom_address !== 18'd499) begin n_err++; $display("FAIL row0_x639_addr: got %0d want 499", rom_address); end
        // RGB now shows pixel 637 -> texel 497.
        n_cmp++; if ({red, green, blue} !== colour(497)) begin n_err++; $display("FAIL row0_x637_rgb: got %h want %h", {red, green, blue}, colour(497)); end
        pix(700, 0, 1'b0);
        n_cmp++; if (rom_address !== 18'd499) begin n_err++; $display("FAIL hblank_hold_addr: got %0d want 499", rom_address); end
    endtask

    task automatic test_last_row;
        pix(0, 0, 1'b1);
        for (int y = 0; y < 479; y++) pix(639, y, 1'b1);
        // 500 source rows over 480 lines: every line end overflows, so row 479 reads texel row 479.
        pix(0, 479, 1'b1);
        n_cmp++; if (rom_address !== 18'd239500) begin n_err++; $display("FAIL row479_x0_addr: got %0d want 239500", rom_address); end
        for (int x = 1; x < 640; x++) pix(x, 479, 1'b1);
        n_cmp++; if (rom_address !== 18'd239999) begin n_err++; $display("FAIL row479_x639_addr: got %0d want 239999", rom_address); end
        pix(0, 480, 1'b0);
        n_cmp++; if (rom_address !== 18'd239999) begin n_err++; $display("FAIL vblank_hold_addr: got %0d want 239999", rom_address); end
    endtask

    task automatic test_mid_reset;
        pix(0, 0, 1'b1);
        for (int x = 1; x < 300; x++) pix(x, 0, 1'b1);
        n_cmp++; if ({red, green, blue} !== colour(232)) begin n_err++; $display("FAIL pre_reset_rgb: got %h want %h", {red, green, blue}, colour(232)); end
        DrawX = 10'd300;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL midreset_rgb: got %h want 000", {red, green, blue}); end
        n_cmp++; if (rom_address !== 18'd0) begin n_err++; $display("FAIL midreset_addr: got %0d want 0", rom_address); end
        pix(300, 0, 1'b1);
        reset_n = 1'b1;
        for (int x = 301; x < 640; x++) begin
            pix(x, 0, 1'b1);
            n_cmp++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL postreset_rgb x=%0d: got %h want 000", x, {red, green, blue}); end
        end
        pix(0, 0, 1'b1);
        pix(1, 0, 1'b1);
        n_cmp++; if ({red, green, blue} !== 12'h000) begin n_err++; $display("FAIL resync_early_rgb: got %h want 000", {red, green, blue}); end
        pix(2, 0, 1'b1);
        n_cmp++; if ({red, green, blue} !== 12'h0F5) begin n_err++; $display("FAIL resync_rgb: got %h want 0f5", {red, green, blue}); end
    endtask

    task automatic test_scroll;
        scroll_step = 4'd7;
        scroll_en   = 1'b1;
        pix(0, 0, 1'b1);
        n_cmp++; if (scroll_x !== 10'd7) begin n_err++; $display("FAIL scroll_f1: got %0d want 7", scroll_x); end
        for (int f = 2; f <= 71; f++) pix(0, 0, 1'b1);
        n_cmp++; if (scroll_x !== 10'd497) begin n_err++; $display("FAIL scroll_f71: got %0d want 497", scroll_x); end
        pix(0, 0, 1'b1);
        n_cmp++; if (scroll_x !== 10'd4) begin n_err++; $display("FAIL scroll_f72_wrap: got %0d want 4", scroll_x); end
        n_cmp++; if (rom_address !== 18'd4) begin n_err++; $display("FAIL scroll_x0_addr: got %0d want 4", rom_address); end
        for (int x = 1; x < 640; x++) begin
            pix(x, 0, 1'b1);
            if (x == 634) begin
                n_cmp++; if (rom_address !== 18'd499) begin n_err++; $display("FAIL scroll_x634_addr: got %0d want 499", rom_address); end
            end
            if (x == 635) begin
                n_cmp++; if (rom_address !== 18'd0) begin n_err++; $display("FAIL scroll_x635_wrap: got %0d want 0", rom_address); end
            end
        end
        n_cmp++; if (rom_address !== 18'd3) begin n_err++; $display("FAIL scroll_x639_addr: got %0d want 3", rom_address); end
    endtask

    task automatic test_scroll_hold;
        for (int x = 0; x < 3; x++) begin
            pix(x, 1, 1'b1);
            n_cmp++; if (scroll_x !== 10'd4) begin n_err++; $display("FAIL midframe_hold x=%0d: got %0d want 4", x, scroll_x); end
            if (x == 0) begin
                n_cmp++; if (rom_address !== 18'd504) begin n_err++; $display("FAIL row1_x0_addr: got %0d want 504", rom_address); end
            end
        end
        scroll_en = 1'b0;
        pix(0, 0, 1'b1);
        n_cmp++; if (scroll_x !== 10'd4) begin n_err++; $display("FAIL en_off_hold: got %0d want 4", scroll_x); end
        n_cmp++; if (rom_address !== 18'd4) begin n_err++; $display("FAIL en_off_addr: got %0d want 4", rom_address); end
        scroll_en   = 1'b1;
        scroll_step = 4'd0;
        pix(0, 0, 1'b1);
        n_cmp++; if (scroll_x !== 10'd4) begin n_err++; $display("FAIL step0_hold: got %0d want 4", scroll_x); end
        scroll_step = 4'd7;
        pix(0, 0, 1'b1);
        n_cmp++; if (scroll_x !== 10'd11) begin n_err++; $display("FAIL step7_resume: got %0d want 11", scroll_x); end
    endtask

    task automatic test_align;
        // floor(p*500/640) + 11 for p = 0..15
        int          addr_tbl [16] = '{11, 11, 12, 13, 14, 14, 15, 16, 17, 18, 18, 19, 20, 21, 21, 22};
        logic [11:0] want;
        scroll_en = 1'b0;
        for (int p = 0; p < 18; p++) begin
            pix(p, 0, (p % 2) == 0);
            if (p >= 2) begin
                want = ((p - 2) % 2 == 0) ? colour(addr_tbl[p-2]) : 12'h000;
                n_cmp++; if ({red, green, blue} !== want) begin n_err++; $display("FAIL align_lat1 p=%0d: got %h want %h", p - 2, {red, green, blue}, want); end
            end
            if (p >= 3) begin
                want = ((p - 3) % 2 == 0) ? colour(addr_tbl[p-3]) : 12'h000;
                n_cmp++; if ({red2, green2, blue2} !== want) begin n_err++; $display("FAIL align_lat2 p=%0d: got %h want %h", p - 3, {red2, green2, blue2}, want); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_row0();
        test_last_row();
        test_mid_reset();
        test_scroll();
        test_scroll_hold();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
